obi_bus_monitor: RTL and testbench

//  Passive, parametrised OBI bus monitor for testbench and debug builds. Breaks out the
//  OBI request/response signals and tracks outstanding transactions in an in-order FIFO.

---
 rtl/hsid_x_obi_mon_pkg.sv | 17 +
 rtl/obi_mon_fifo.sv | 49 ++++
 rtl/obi_bus_monitor.sv | 161 ++++++++++++++++
 tb/tb_obi_bus_monitor.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hsid_x_obi_mon_pkg.sv
// Shared definitions for the OBI bus monitor: error-bit indices and a saturating increment.
package hsid_x_obi_mon_pkg;

  localparam int unsigned ERR_NO_OUTST = 0;
  localparam int unsigned ERR_OVERFLOW = 1;
  localparam int unsigned ERR_UNSTABLE = 2;
  localparam int unsigned ERR_ZERO_BE  = 3;
  localparam int unsigned ERR_W        = 4;

  // Counters up to 32 bits wide are routed through this; callers narrow the result.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (val >= max_v) ? max_v : val + 32'd1;
  endfunction

endpackage

// File: rtl/obi_mon_fifo.sv
// Synchronous in-order FIFO for outstanding OBI transactions; push while full is
// accepted only when a pop happens in the same cycle.
module obi_mon_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (!do_push && do_pop) count_q <= count_q - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/obi_bus_monitor.sv
// Passive OBI monitor: transaction records, performance counters, sticky protocol errors.
// Optional trace output enabled by defining OBI_MON_TRACE_EN.
module obi_bus_monitor
  import hsid_x_obi_mon_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req,
  input  logic                              we,
  input  logic [DATA_WIDTH/8-1:0]           be,
  input  logic [ADDR_WIDTH-1:0]             addr,
  input  logic [DATA_WIDTH-1:0]             wdata,
  input  logic                              gnt,
  input  logic                              rvalid,
  input  logic [DATA_WIDTH-1:0]             rdata,
  input  logic                              clr,
  output logic                              txn_valid,
  output logic                              txn_we,
  output logic [DATA_WIDTH/8-1:0]           txn_be,
  output logic [ADDR_WIDTH-1:0]             txn_addr,
  output logic [DATA_WIDTH-1:0]             txn_data,
  output logic [CNT_WIDTH-1:0]              txn_latency,
  output logic [CNT_WIDTH-1:0]              rd_count,
  output logic [CNT_WIDTH-1:0]              wr_count,
  output logic [CNT_WIDTH-1:0]              stall_count,
  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
  output logic [3:0]                        err
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned PH_W  = 1 + BE_W + ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned E_W   = PH_W + CNT_WIDTH;
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic                  accept, pop_v, fifo_full, fifo_empty;
  logic [E_W-1:0]        head;
  logic [PH_W-1:0]       phase;
  logic                  h_we;
  logic [BE_W-1:0]       h_be;
  logic [ADDR_WIDTH-1:0] h_addr;
  logic [DATA_WIDTH-1:0] h_wdata;
  logic [CNT_WIDTH-1:0]  h_stamp;

  logic [CNT_WIDTH-1:0]  stamp_q;
  logic [CNT_WIDTH-1:0]  rd_q, rd_d, wr_q, wr_d, stall_q, stall_d;
  logic [ERR_W-1:0]      err_q, err_d, err_new;
  logic                  cap_valid_q;
  logic [PH_W-1:0]       cap_q;
  logic                  txn_valid_q, txn_we_q;
  logic [BE_W-1:0]       txn_be_q;
  logic [ADDR_WIDTH-1:0] txn_addr_q;
  logic [DATA_WIDTH-1:0] txn_data_q;
  logic [CNT_WIDTH-1:0]  txn_lat_q;

  assign phase  = {we, be, addr, wdata};
  assign accept = req & gnt;
  assign pop_v  = rvalid & ~fifo_empty;
  assign {h_we, h_be, h_addr, h_wdata, h_stamp} = head;

  obi_mon_fifo #(
    .WIDTH (E_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .wdata_i ({phase, stamp_q}),
    .pop_i   (pop_v),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding)
  );

  // clr and a same-cycle event combine as "clear, then apply": new errors and counts survive.
  always_comb begin
    err_new                = '0;
    err_new[ERR_NO_OUTST]  = rvalid & fifo_empty;
    err_new[ERR_OVERFLOW]  = accept & fifo_full & ~pop_v;
    err_new[ERR_UNSTABLE]  = cap_valid_q & req & (phase != cap_q);
    err_new[ERR_ZERO_BE]   = accept & we & (be == '0);
    err_d   = (clr ? '0 : err_q) | err_new;
    rd_d    = clr ? '0 : rd_q;
    wr_d    = clr ? '0 : wr_q;
    stall_d = clr ? '0 : stall_q;
    if (accept && !we) rd_d    = CNT_WIDTH'(sat_inc(32'(rd_d), CNT_WIDTH));
    if (accept && we)  wr_d    = CNT_WIDTH'(sat_inc(32'(wr_d), CNT_WIDTH));
    if (req && !gnt)   stall_d = CNT_WIDTH'(sat_inc(32'(stall_d), CNT_WIDTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stamp_q     <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      stall_q     <= '0;
      err_q       <= '0;
      cap_valid_q <= 1'b0;
      cap_q       <= '0;
      txn_valid_q <= 1'b0;
      txn_we_q    <= 1'b0;
      txn_be_q    <= '0;
      txn_addr_q  <= '0;
      txn_data_q  <= '0;
      txn_lat_q   <= '0;
    end else begin
      stamp_q     <= stamp_q + CNT_WIDTH'(1);
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      stall_q     <= stall_d;
      err_q       <= err_d;
      cap_valid_q <= req & ~gnt;
      if (req && !gnt) cap_q <= phase;
      txn_valid_q <= pop_v;
      if (pop_v) begin
        txn_we_q   <= h_we;
        txn_be_q   <= h_be;
        txn_addr_q <= h_addr;
        txn_data_q <= h_we ? h_wdata : rdata;
        txn_lat_q  <= stamp_q - h_stamp;
      end else if (clr) begin
        txn_we_q   <= 1'b0;
        txn_be_q   <= '0;
        txn_addr_q <= '0;
        txn_data_q <= '0;
        txn_lat_q  <= '0;
      end
    end
  end

  assign txn_valid   = txn_valid_q;
  assign txn_we      = txn_we_q;
  assign txn_be      = txn_be_q;
  assign txn_addr    = txn_addr_q;
  assign txn_data    = txn_data_q;
  assign txn_latency = txn_lat_q;
  assign rd_count    = rd_q;
  assign wr_count    = wr_q;
  assign stall_count = stall_q;
  assign err         = err_q;

`ifdef OBI_MON_TRACE_EN
  always_ff @(posedge clk) begin
    if (txn_valid_q)
      $display("[OBI] t=%0t %s addr=0x%h be=0x%h data=0x%h lat=%0d", $time,
               txn_we_q ? "W" : "R", txn_addr_q, txn_be_q, txn_data_q, txn_lat_q);
    if (!rst) begin
      for (int unsigned i = 0; i < ERR_W; i++)
        if (err_d[i] && !err_q[i]) $error("[OBI] protocol error bit %0d raised", i);
    end
  end
`else
  // Silent build: no simulation output.
`endif

endmodule

// File: tb/tb_obi_bus_monitor.sv
// Self-checking bench for obi_bus_monitor (CNT_WIDTH=4 so saturation and stamp wrap are reachable).
module tb_obi_bus_monitor;

  localparam int MAXC = 15;
  localparam int NSTAMP = 16;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, req, we, gnt, rvalid, clr;
  logic [3:0]  be;
  logic [31:0] addr, wdata, rdata;
  logic        txn_valid, txn_we;
  logic [3:0]  txn_be;
  logic [31:0] txn_addr, txn_data;
  logic [3:0]  txn_latency, rd_count, wr_count, stall_count;
  logic [2:0]  outstanding;
  logic [3:0]  err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  obi_bus_monitor #(
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32),
    .MAX_OUTSTANDING (4),
    .CNT_WIDTH       (4)
  ) dut (
    .clk (clk), .rst (rst), .req (req), .we (we), .be (be), .addr (addr),
    .wdata (wdata), .gnt (gnt), .rvalid (rvalid), .rdata (rdata), .clr (clr),
    .txn_valid (txn_valid), .txn_we (txn_we), .txn_be (txn_be), .txn_addr (txn_addr),
    .txn_data (txn_data), .txn_latency (txn_latency), .rd_count (rd_count),
    .wr_count (wr_count), .stall_count (stall_count), .outstanding (outstanding),
    .err (err)
  );

  // Reference model: queue of in-flight records plus plain integer counters.
  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stamp;
  } rec_t;

  rec_t        q[$];
  int          m_stamp, m_rd, m_wr, m_stall, m_tlat;
  logic [3:0]  m_err, m_tbe;
  bit          m_capv, m_tv, m_twe;
  logic [68:0] m_cap;
  logic [31:0] m_taddr, m_tdata;

  function automatic int sat(input int v);
    return (v + 1 > MAXC) ? MAXC : v + 1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_stamp = 0; m_rd = 0; m_wr = 0; m_stall = 0; m_err = '0;
    m_capv = 0; m_cap = '0;
    m_tv = 0; m_twe = 0; m_tbe = '0; m_taddr = '0; m_tdata = '0; m_tlat = 0;
  endtask

  task automatic model_edge();
    rec_t h;
    bit acc, popv;
    logic [3:0] ne;
    logic [68:0] ph;
    if (rst) begin
      model_reset();
      return;
    end
    ph   = {we, be, addr, wdata};
    acc  = req && gnt;
    popv = rvalid && (q.size() != 0);
    ne   = '0;
    if (rvalid && q.size() == 0)              ne[0] = 1'b1;
    if (acc && q.size() == DEPTH && !popv)    ne[1] = 1'b1;
    if (m_capv && req && ph !== m_cap)        ne[2] = 1'b1;
    if (acc && we && be == 4'h0)              ne[3] = 1'b1;
    m_tv = popv;
    if (popv) begin
      h = q.pop_front();
      m_twe = h.we; m_tbe = h.be; m_taddr = h.addr;
      m_tdata = h.we ? h.wdata : rdata;
      m_tlat = (m_stamp - h.stamp + NSTAMP) % NSTAMP;
    end else if (clr) begin
      m_twe = 0; m_tbe = '0; m_taddr = '0; m_tdata = '0; m_tlat = 0;
    end
    if (acc && q.size() < DEPTH) q.push_back('{we, be, addr, wdata, m_stamp});
    if (clr) begin m_rd = 0; m_wr = 0; m_stall = 0; m_err = '0; end
    if (acc && !we)   m_rd = sat(m_rd);
    if (acc && we)    m_wr = sat(m_wr);
    if (req && !gnt)  m_stall = sat(m_stall);
    m_err = m_err | ne;
    m_capv = req && !gnt;
    if (m_capv) m_cap = ph;
    m_stamp = (m_stamp + 1) % NSTAMP;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("txn_valid",   64'(txn_valid),   64'(m_tv));
    chk("txn_we",      64'(txn_we),      64'(m_twe));
    chk("txn_be",      64'(txn_be),      64'(m_tbe));
    chk("txn_addr",    64'(txn_addr),    64'(m_taddr));
    chk("txn_data",    64'(txn_data),    64'(m_tdata));
    chk("txn_latency", 64'(txn_latency), 64'(m_tlat));
    chk("rd_count",    64'(rd_count),    64'(m_rd));
    chk("wr_count",    64'(wr_count),    64'(m_wr));
    chk("stall_count", 64'(stall_count), 64'(m_stall));
    chk("outstanding", 64'(outstanding), 64'(q.size()));
    chk("err",         64'(err),         64'(m_err));
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_idle();
    rst = 0; req = 0; we = 0; be = '0; addr = '0; wdata = '0;
    gnt = 0; rvalid = 0; rdata = '0; clr = 0;
  endtask

  task automatic drive_req(input bit w, input logic [31:0] a, input logic [31:0] d, input bit g);
    req = 1; we = w; be = 4'hF; addr = a; wdata = d; gnt = g;
  endtask

  initial begin
    model_reset();
    set_idle();
    rst = 1;
    cyc(); cyc();
    rst = 0;
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_err",         64'(err),         64'd0);

    // Single read, latency 3
    drive_req(0, 32'h100, 32'h0, 1); cyc();
    set_idle(); cyc(); cyc();
    rvalid = 1; rdata = 32'hDEADBEEF; cyc();
    chk("t1_valid", 64'(txn_valid),   64'd1);
    chk("t1_we",    64'(txn_we),      64'd0);
    chk("t1_data",  64'(txn_data),    64'hDEADBEEF);
    chk("t1_lat",   64'(txn_latency), 64'd3);
    chk("t1_rd",    64'(rd_count),    64'd1);
    set_idle(); cyc();

    // Four back-to-back writes, drained in order
    for (int i = 0; i < 4; i++) begin
      drive_req(1, 32'h200 + 32'(4 * i), 32'hA0 + 32'(i), 1); cyc();
    end
    set_idle();
    chk("t2_out4", 64'(outstanding), 64'd4);
    for (int i = 0; i < 4; i++) begin
      rvalid = 1; rdata = 32'h5555_0000; cyc();
      chk("t2_addr", 64'(txn_addr), 64'h200 + 64'(4 * i));
      chk("t2_data", 64'(txn_data), 64'hA0 + 64'(i));
    end
    set_idle(); cyc();
    chk("t2_out0", 64'(outstanding), 64'd0);
    chk("t2_wr",   64'(wr_count),    64'd4);
    chk("t2_err",  64'(err),         64'd0);

    // Unstable address during stall
    drive_req(0, 32'h300, 32'h0, 0); cyc();
    addr = 32'h304; cyc();
    chk("t3_err",   64'(err),         64'h4);
    chk("t3_stall", 64'(stall_count), 64'd2);
    set_idle(); cyc();

    // Stray rvalid, then clr
    rvalid = 1; cyc();
    chk("t4_err0",  64'(err[0]),    64'd1);
    chk("t4_novld", 64'(txn_valid), 64'd0);
    set_idle(); clr = 1; cyc();
    set_idle();
    chk("t4_clr_err", 64'(err),         64'd0);
    chk("t4_clr_rd",  64'(rd_count),    64'd0);
    chk("t4_clr_wr",  64'(wr_count),    64'd0);
    chk("t4_clr_st",  64'(stall_count), 64'd0);

    // Overflow on fifth accept
    for (int i = 0; i < 5; i++) begin
      drive_req(0, 32'h400 + 32'(4 * i), 32'h0, 1); cyc();
    end
    set_idle();
    chk("t5_err1", 64'(err),         64'h2);
    chk("t5_out",  64'(outstanding), 64'd4);
    for (int i = 0; i < 4; i++) begin
      rvalid = 1; rdata = 32'(i); cyc();
    end
    chk("t5_last_addr", 64'(txn_addr), 64'h40C);
    set_idle(); clr = 1; cyc(); set_idle();

    // Simultaneous accept and pop
    drive_req(1, 32'h500, 32'h11, 1); cyc();
    drive_req(1, 32'h504, 32'h22, 1); rvalid = 1; cyc();
    chk("t6_out1", 64'(outstanding), 64'd1);
    chk("t6_vld",  64'(txn_valid),   64'd1);
    set_idle(); rvalid = 1; cyc();
    chk("t6_data2", 64'(txn_data), 64'h22);
    set_idle();
    // Stamp wrap: accept at stamp 13, respond five cycles later
    for (int i = 0; i < NSTAMP && m_stamp != 13; i++) cyc();
    drive_req(0, 32'h600, 32'h0, 1); cyc();
    set_idle(); cyc(); cyc(); cyc(); cyc();
    rvalid = 1; rdata = 32'hCAFE; cyc();
    chk("t6_wrap_lat", 64'(txn_latency), 64'd5);
    set_idle(); cyc();

    // Reset mid-transaction flushes the FIFO
    drive_req(0, 32'h700, 32'h0, 1); cyc();
    set_idle(); rst = 1; cyc();
    set_idle(); rvalid = 1; cyc();
    chk("rst_mid_err0", 64'(err[0]),    64'd1);
    chk("rst_mid_vld",  64'(txn_valid), 64'd0);
    set_idle(); clr = 1; cyc(); set_idle();

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      clr = ($urandom_range(0, 39) == 0);
      if (!(m_capv && $urandom_range(0, 9) != 0)) begin
        req   = 1'($urandom_range(0, 1));
        we    = 1'($urandom_range(0, 1));
        be    = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
        addr  = $urandom;
        wdata = $urandom;
      end
      gnt    = ($urandom_range(0, 2) != 0);
      rvalid = ($urandom_range(0, 2) == 0);
      rdata  = $urandom;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
